// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the 6502 stack access sequencer.
package stack_pkg;

  typedef enum logic [1:0] {
    PUSH1 = 2'd0,
    PUSH2 = 2'd1,
    PULL1 = 2'd2,
    PULL2 = 2'd3
  } stack_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_DONE = 2'd3
  } stack_state_t;

  localparam logic [7:0] DEFAULT_STACK_PAGE = 8'h01;

  function automatic logic is_push(stack_op_t op);
    return (op == PUSH1) || (op == PUSH2);
  endfunction

  function automatic logic is_two_byte(stack_op_t op);
    return (op == PUSH2) || (op == PULL2);
  endfunction

endpackage

// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - push/pull bus sequencer feeding the external S register.
// Optional wrap flags (stk_ovf/stk_unf/wrap_clr) are built when STACK_WRAP_DETECT_EN is defined.
module stack_seq
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = DEFAULT_STACK_PAGE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic [7:0]  s_in,
  output logic        s_load,
  output logic [7:0]  s_next,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
`ifdef STACK_WRAP_DETECT_EN
  ,
  output logic        stk_ovf,
  output logic        stk_unf,
  input  logic        wrap_clr
`endif
);

  stack_state_t state, state_nxt;
  stack_op_t    op_q;
  logic [15:0]  wdata_q;
  logic [7:0]   sp_w;
  logic [7:0]   lo_q;
  logic         accept;
  logic         in_acc;
  logic         acc_done;
  logic         op_push;

  assign accept   = (state == ST_IDLE) && cmd_valid;
  assign in_acc   = (state == ST_ACC1) || (state == ST_ACC2);
  assign acc_done = in_acc && mem_ack;
  assign op_push  = is_push(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nxt = ST_ACC1;
      ST_ACC1: if (mem_ack) state_nxt = is_two_byte(op_q) ? ST_ACC2 : ST_DONE;
      ST_ACC2: if (mem_ack) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Final pull data is registered on the last ack so it is already visible in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= PUSH1;
      wdata_q   <= '0;
      sp_w      <= '0;
      lo_q      <= '0;
      rsp_rdata <= '0;
    end else if (accept) begin
      op_q    <= stack_op_t'(cmd_op);
      wdata_q <= cmd_wdata;
      sp_w    <= is_push(stack_op_t'(cmd_op)) ? s_in : s_in + 8'd1;
    end else if (acc_done) begin
      if (op_push) begin
        sp_w <= sp_w - 8'd1;
      end else if (state == ST_ACC1 && op_q == PULL2) begin
        sp_w <= sp_w + 8'd1;
        lo_q <= mem_rdata;
      end else if (state == ST_ACC1) begin
        rsp_rdata <= {8'h00, mem_rdata};
      end else begin
        rsp_rdata <= {mem_rdata, lo_q};
      end
    end
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_DONE);
    s_load    = (state == ST_DONE);
    s_next    = (state == ST_DONE) ? sp_w : 8'h00;
    mem_req   = in_acc;
    mem_we    = in_acc && op_push;
    mem_addr  = in_acc ? {STACK_PAGE, sp_w} : 16'h0000;
    mem_wdata = 8'h00;
    if (in_acc && op_push) begin
      mem_wdata = (state == ST_ACC1 && op_q == PUSH2) ? wdata_q[15:8] : wdata_q[7:0];
    end
  end

`ifdef STACK_WRAP_DETECT_EN
  logic ovf_set, unf_set;

  // Underflow can occur at accept (S = FF) or on the mid-PULL2 increment.
  assign ovf_set = acc_done && op_push && (sp_w == 8'h00);
  assign unf_set = (accept && !is_push(stack_op_t'(cmd_op)) && (s_in == 8'hFF)) ||
                   (acc_done && state == ST_ACC1 && op_q == PULL2 && (sp_w == 8'hFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      stk_ovf <= ovf_set || (stk_ovf && !wrap_clr);
      stk_unf <= unf_set || (stk_unf && !wrap_clr);
    end
  end
`endif

endmodule

// File: doc/stack_seq.md
# stack_seq

Stack access sequencer for the 6502 core. Accepts 1- or 2-byte push/pull commands from the control unit and runs the bus cycles to page-1 memory (0x0100 | S). It computes the new stack pointer and loads it into the external 8-bit S register with a single `s_load`/`s_next` pulse per command. It sits directly upstream of the S register and reads that register's current value back on `s_in`.

## Interface
Parameters:
- `STACK_PAGE`, 8'h01, high address byte of the stack page.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  sequencer idle; command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  operation: 0 PUSH1, 1 PUSH2, 2 PULL1, 3 PULL2.
- `cmd_wdata`  in  16  push data; PUSH1 uses [7:0].
- `rsp_valid`  out  1  one-cycle completion pulse, for every op.
- `rsp_rdata`  out  16  pulled data; PULL1 zero-extends.
- `s_in`  in  8  current S register value.
- `s_load`  out  1  S register load strobe.
- `s_next`  out  8  new S value, valid when `s_load` is high.
- `mem_req`  out  1  bus access request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  16  `{STACK_PAGE, sp_w}`.
- `mem_wdata`  out  8  write byte.
- `mem_rdata`  in  8  read byte, valid with `mem_ack`.
- `mem_ack`  in  1  access complete; ignored while `mem_req` is low.

## Operation
- States: IDLE, ACC1, ACC2, DONE. `cmd_ready` = (state == IDLE).
- Accept in IDLE latches `op` and `wdata`, and sets internal pointer `sp_w`:
  - push: `sp_w = s_in`.
  - pull: `sp_w = s_in + 1`.
- Transitions:
  - ACC1 → ACC2 on `mem_ack` for 2-byte ops.
  - ACC1 → DONE on `mem_ack` for 1-byte ops.
  - ACC2 → DONE on `mem_ack`.
  - DONE → IDLE unconditionally.
- Push semantics: write at `sp_w`, then `sp_w -= 1`. PUSH2 writes the high byte first, then the low byte (JSR order).
- Pull semantics: read at `sp_w` and capture the byte; for PULL2, `sp_w += 1` after the first ack. PULL2 reads the low byte first, then the high byte (RTS order).
- DONE: `s_load = 1`, `s_next = sp_w` (final value), `rsp_valid = 1`. For pulls, `rsp_rdata` updates in the same cycle and then holds until the next pull completes; pushes leave it unchanged.
- Arithmetic: 8-bit modulo 256.
  - Push at S = 00 writes 0x0100 and leaves S = FF.
  - Pull at S = FF reads 0x0100 and leaves S = 00.
- No S write occurs before DONE. The control unit does not load S from any other source while `cmd_ready` = 0.
- Reset values: state IDLE; `cmd_ready` = 1; `rsp_valid`, `s_load`, `mem_req`, `mem_we` = 0; `rsp_rdata`, `s_next`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-command: the command is aborted immediately, there is no `s_load`, and the partial `rsp_rdata` is discarded (cleared to 0).

## Timing
- T0: accept.
- T1: `mem_req` high, with `mem_addr`, `mem_we` and `mem_wdata` stable. They hold until the `mem_ack` cycle.
- Zero-wait memory:
  - 1-byte op: ack in T1, DONE in T2, `cmd_ready` in T3.
  - 2-byte op: second access in T2, DONE in T3.
- Each wait cycle (`mem_req` high, `mem_ack` low) adds exactly one cycle.
- `mem_req` drops in DONE. The two accesses of a 2-byte op are back-to-back; `mem_req` stays high and the address changes in the cycle after the first ack.
- `cmd_valid` during busy states is ignored, not queued.

## Configuration
- Macro `STACK_WRAP_DETECT_EN`.
- Defined:
  - Adds outputs `stk_ovf` and `stk_unf` (1 bit each, reset 0) and input `wrap_clr`.
  - `stk_ovf` becomes 1 in the cycle after an access where a push decrements `sp_w` from 00 to FF.
  - `stk_unf` becomes 1 in the cycle after an access where a pull increments `sp_w` from FF to 00, including at accept.
  - Both flags are sticky. `wrap_clr` clears both; if `wrap_clr` coincides with a new wrap event, set wins.
- Undefined: the ports are absent and the logic is removed. Stack behaviour is otherwise identical.

## Structure
- Shared package `stack_pkg`:
  - `stack_op_t` enum (PUSH1, PUSH2, PULL1, PULL2).
  - `stack_state_t` enum.
  - `DEFAULT_STACK_PAGE` = 8'h01.
- No sub-module: a single FSM plus datapath. The S register remains an external instance.

## Test plan
- PUSH1 `wdata` = 0x00AB, `s_in` = FD, zero-wait → write 0x01FD = AB in T1; `s_load` with `s_next` = FC in T2; `rsp_valid` in T2.
- PUSH2 0x1234, `s_in` = FF, 2 wait cycles per access → write 0x01FF = 12, then 0x01FE = 34; `s_next` = FD; DONE at T7.
- PULL2, `s_in` = FD, memory 0x01FE = 34 and 0x01FF = 12 → `rsp_rdata` = 0x1234, `s_next` = FF.
- Wrap: PUSH1 at `s_in` = 00 → write 0x0100, `s_next` = FF, `stk_ovf` = 1 (macro on). PULL1 at `s_in` = FF → read 0x0100, `s_next` = 00, `stk_unf` = 1.
- `cmd_valid` held high through a PULL1 → second command accepted only in the IDLE cycle after DONE. `mem_ack` pulsed while `mem_req` = 0 → no effect.
- `rst_n` low during ACC2 of a PUSH2 → all outputs at reset values in the same cycle; no `s_load`; `cmd_ready` = 1 after release.
